dispense_arbiter: RTL and testbench

Shares one ticket printer and one change-coin hopper between `NUM_REQ` vending front-ends. Each front-end posts a job once its fare is settled: a ticket count and a change amount. The block grants jobs round-robin and sequences the printer strobes and coin strobes for each job. It greedily selects coin denominations, skips empty hopper tubes, and reports any change it cannot pay.

---
 rtl/vm_pkg.sv | 47 ++++
 rtl/dispense_arbiter_if.sv | 17 +
 rtl/dispense_arbiter_rr_arbiter.sv | 40 ++++
 rtl/dispense_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_dispense_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending definitions: FSM states, coin encoding, denomination values
// and field widths common to the dispense arbiter and the vending front-ends.
package vm_pkg;

  localparam int CHANGE_W    = 7;
  localparam int TICKET_W    = 3;
  localparam int MAX_TICKETS = 5;
  localparam int NUM_DENOM   = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TICKET_ON  = 3'd1,
    ST_TICKET_GAP = 3'd2,
    ST_COIN_ON    = 3'd3,
    ST_COIN_GAP   = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2,
    COIN_50 = 2'd3
  } coin_sel_t;

  localparam logic [CHANGE_W-1:0] DENOM_VALUE [NUM_DENOM] = '{7'd1, 7'd5, 7'd10, 7'd50};

  // Greedy pick: largest non-empty denomination not exceeding amount.
  // Returns {found, coin_sel}; found = 0 means no tube can pay anything.
  function automatic logic [2:0] pick_coin(input logic [CHANGE_W-1:0] amount,
                                           input logic [NUM_DENOM-1:0] empty);
    logic [2:0] pick;
    if (!empty[3] && (amount >= DENOM_VALUE[3])) begin
      pick = {1'b1, COIN_50};
    end else if (!empty[2] && (amount >= DENOM_VALUE[2])) begin
      pick = {1'b1, COIN_10};
    end else if (!empty[1] && (amount >= DENOM_VALUE[1])) begin
      pick = {1'b1, COIN_5};
    end else if (!empty[0] && (amount >= DENOM_VALUE[0])) begin
      pick = {1'b1, COIN_1};
    end else begin
      pick = 3'b000;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dispense_arbiter_if.sv
// Front-end job bus: requests flow in, accept and completion flow back.
interface dispense_arbiter_if #(parameter int NUM_REQ = 4);
  import vm_pkg::*;

  logic [NUM_REQ-1:0]          req_valid;
  logic [TICKET_W*NUM_REQ-1:0] req_tickets;
  logic [CHANGE_W*NUM_REQ-1:0] req_change;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          done;
  logic                        err;
  logic [CHANGE_W-1:0]         shortfall;

  modport master (output req_valid, req_tickets, req_change,
                  input  req_ready, done, err, shortfall);
  modport slave  (input  req_valid, req_tickets, req_change,
                  output req_ready, done, err, shortfall);
endinterface

// File: rtl/dispense_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int ID_W = $clog2(N);

  int              cand_s;
  logic [ID_W-1:0] cand_idx_s;

  // Scan candidates ptr, ptr+1, ... modulo N and keep the first requester.
  always_comb begin
    grant      = '0;
    idx        = '0;
    any        = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = int'(ptr) + i;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[ID_W-1:0];
      if (!any && req[cand_idx_s]) begin
        any               = 1'b1;
        grant[cand_idx_s] = 1'b1;
        idx               = cand_idx_s;
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/dispense_arbiter.sv
// Round-robin sharing of one ticket printer and one coin hopper between
// NUM_REQ front-ends; sequences ticket and coin strobes, pays change greedily.
module dispense_arbiter
  import vm_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  dispense_arbiter_if.slave          bus,
  input  logic [3:0]                 hopper_empty,
  output logic                       ticket_strobe,
  output logic                       coin_strobe,
  output logic [1:0]                 coin_sel,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t              state_r, state_s;
  logic [TICKET_W-1:0] tickets_r, tickets_s;
  logic [CHANGE_W-1:0] remaining_r, remaining_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  coin_sel_t           coin_sel_r, coin_sel_s;
  logic [ID_W-1:0]     active_r, active_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic                err_r, err_s;
  logic [CHANGE_W-1:0] short_r, short_s;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                grant_any_s;
  logic [TICKET_W-1:0] grant_tickets_s;
  logic [CHANGE_W-1:0] grant_change_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [NUM_REQ-1:0]  done_s;

  logic [CHANGE_W-1:0] dec_amount_s;
  logic [2:0]          dec_pick_s;
  state_t              dec_state_s;
  logic                dec_err_s;
  logic [CHANGE_W-1:0] dec_short_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s),
    .any   (grant_any_s)
  );

  // Mux out the granted front-end's job fields (one-hot AND-OR).
  always_comb begin
    grant_tickets_s = '0;
    grant_change_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_tickets_s = grant_tickets_s |
        ({TICKET_W{grant_s[i]}} & TICKET_W'(bus.req_tickets >> (TICKET_W * i)));
      grant_change_s  = grant_change_s |
        ({CHANGE_W{grant_s[i]}} & CHANGE_W'(bus.req_change >> (CHANGE_W * i)));
    end
  end

  // Coin decision: from IDLE it uses the incoming change, elsewhere the remainder.
  always_comb begin
    dec_amount_s = (state_r == ST_IDLE) ? grant_change_s : remaining_r;
    dec_pick_s   = pick_coin(dec_amount_s, hopper_empty);
    dec_err_s    = 1'b0;
    dec_short_s  = '0;
    if (dec_amount_s == '0) begin
      dec_state_s = ST_DONE;
    end else if (dec_pick_s[2]) begin
      dec_state_s = ST_COIN_ON;
    end else begin
      dec_state_s = ST_DONE;
      dec_err_s   = 1'b1;
      dec_short_s = dec_amount_s;
    end
  end

  // Next-state and datapath updates for the job sequencer.
  always_comb begin
    state_s     = state_r;
    tickets_s   = tickets_r;
    remaining_s = remaining_r;
    cnt_s       = cnt_r;
    coin_sel_s  = coin_sel_r;
    active_s    = active_r;
    rr_ptr_s    = rr_ptr_r;
    err_s       = err_r;
    short_s     = short_r;
    req_ready_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          req_ready_s = grant_s;
          active_s    = grant_idx_s;
          tickets_s   = grant_tickets_s;
          remaining_s = grant_change_s;
          err_s       = 1'b0;
          short_s     = '0;
          if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = grant_idx_s + ID_W'(1);
          end
          if (grant_tickets_s > TICKET_W'(MAX_TICKETS)) begin
            state_s = ST_DONE;
            err_s   = 1'b1;
          end else if (grant_tickets_s != '0) begin
            state_s = ST_TICKET_ON;
            cnt_s   = PULSE_LOAD;
          end else begin
            state_s    = dec_state_s;
            coin_sel_s = coin_sel_t'(dec_pick_s[1:0]);
            cnt_s      = PULSE_LOAD;
            err_s      = dec_err_s;
            short_s    = dec_short_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TICKET_ON: begin
        if (cnt_r == '0) begin
          state_s   = ST_TICKET_GAP;
          cnt_s     = GAP_LOAD;
          tickets_s = tickets_r - TICKET_W'(1);
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_TICKET_GAP: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (tickets_r != '0) begin
          state_s = ST_TICKET_ON;
          cnt_s   = PULSE_LOAD;
        end else begin
          state_s    = dec_state_s;
          coin_sel_s = coin_sel_t'(dec_pick_s[1:0]);
          cnt_s      = PULSE_LOAD;
          err_s      = dec_err_s;
          short_s    = dec_short_s;
        end
      end
      ST_COIN_ON: begin
        if (cnt_r == '0) begin
          state_s     = ST_COIN_GAP;
          cnt_s       = GAP_LOAD;
          remaining_s = remaining_r - DENOM_VALUE[coin_sel_r];
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_COIN_GAP: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s    = dec_state_s;
          coin_sel_s = coin_sel_t'(dec_pick_s[1:0]);
          cnt_s      = PULSE_LOAD;
          err_s      = dec_err_s;
          short_s    = dec_short_s;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tickets_r   <= '0;
      remaining_r <= '0;
      cnt_r       <= '0;
      coin_sel_r  <= COIN_1;
      active_r    <= '0;
      rr_ptr_r    <= '0;
      err_r       <= 1'b0;
      short_r     <= '0;
    end else begin
      state_r     <= state_s;
      tickets_r   <= tickets_s;
      remaining_r <= remaining_s;
      cnt_r       <= cnt_s;
      coin_sel_r  <= coin_sel_s;
      active_r    <= active_s;
      rr_ptr_r    <= rr_ptr_s;
      err_r       <= err_s;
      short_r     <= short_s;
    end
  end

  // Completion pulse routed to the owning front-end.
  always_comb begin
    done_s = '0;
    if (state_r == ST_DONE) begin
      done_s[active_r] = 1'b1;
    end else begin
      done_s = '0;
    end
  end

  assign bus.req_ready  = reset ? '0 : req_ready_s;
  assign bus.done       = done_s;
  assign bus.err        = (state_r == ST_DONE) & err_r;
  assign bus.shortfall  = (state_r == ST_DONE) ? short_r : '0;
  assign busy           = (state_r != ST_IDLE);
  assign ticket_strobe  = (state_r == ST_TICKET_ON);
  assign coin_strobe    = (state_r == ST_COIN_ON);
  assign coin_sel       = coin_strobe ? coin_sel_r : 2'd0;
  assign active_id      = busy ? active_r : '0;

endmodule

// File: tb/tb_dispense_arbiter.sv
// Bench for dispense_arbiter: a queue-based timeline model checked every cycle,
// plus hand-computed expectations for the documented scenarios.
module tb_dispense_arbiter;
  localparam int N = 4;
  localparam int P = 4;
  localparam int G = 2;

  typedef struct packed {
    logic       t;
    logic       c;
    logic [1:0] sel;
    logic       d;
    logic       e;
    logic [6:0] sh;
  } ent_t;

  logic       clk;
  logic       reset;
  logic [3:0] hopper;
  logic       ticket_strobe, coin_strobe, busy;
  logic [1:0] coin_sel, active_id;

  dispense_arbiter_if #(.NUM_REQ(N)) bus ();

  dispense_arbiter #(.NUM_REQ(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .hopper_empty  (hopper),
    .ticket_strobe (ticket_strobe),
    .coin_strobe   (coin_strobe),
    .coin_sel      (coin_sel),
    .busy          (busy),
    .active_id     (active_id)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv [4] = '{1, 5, 10, 50};

  ent_t m_q[$];
  int   m_rr = 0;
  int   m_active = 0;

  int grant_n = 0, done_n = 0, grant_cyc = 0, done_off = 0;
  int grant_log [64];
  int done_log [64];
  int t_rise [8];
  int c_rise [16];
  int t_n = 0, c_n = 0, rec_err = 0, rec_short = 0;
  logic [19:0] rec_seq = 20'd0;
  logic prev_t = 1'b0, prev_c = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (((v >> k) & 4'b0001) != 4'b0000) return k;
    return -1;
  endfunction

  function automatic int m_pick(input int rr, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (rr + k) % 4;
      if (((v >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  // Expected per-cycle timeline of one job, from the cycle after its grant.
  function automatic void build(input int t, input int c, input logic [3:0] emp);
    ent_t e;
    int rem, best;
    e = '0;
    if (t > 5) begin
      e.d = 1'b1; e.e = 1'b1; m_q.push_back(e);
      return;
    end
    for (int k = 0; k < t; k++) begin
      e = '0; e.t = 1'b1;
      repeat (P) m_q.push_back(e);
      e = '0;
      repeat (G) m_q.push_back(e);
    end
    rem = c;
    while (rem > 0) begin
      best = -1;
      for (int d = 0; d < 4; d++)
        if ((((emp >> d) & 4'b0001) == 4'b0000) && dv[d] <= rem) best = d;
      if (best < 0) break;
      e = '0; e.c = 1'b1; e.sel = 2'(best);
      repeat (P) m_q.push_back(e);
      e = '0;
      repeat (G) m_q.push_back(e);
      rem = rem - dv[best];
    end
    e = '0; e.d = 1'b1; e.e = (rem != 0); e.sh = 7'(rem);
    m_q.push_back(e);
  endfunction

  // Every-cycle compare against the model, event logging, model advance.
  always @(negedge clk) begin : cmp
    ent_t e;
    int exp_ready, exp_busy, gi, tk, ch;
    e = '0; exp_ready = 0; exp_busy = 0; gi = -1;
    if (reset) begin
      m_q.delete(); m_rr = 0; m_active = 0;
    end else if (m_q.size() != 0) begin
      e = m_q[0]; exp_busy = 1;
    end else if (bus.req_valid != 4'b0000) begin
      gi = m_pick(m_rr, bus.req_valid); exp_ready = 1 << gi;
    end
    chk("req_ready", int'(bus.req_ready), exp_ready);
    chk("ticket_strobe", int'(ticket_strobe), int'(e.t));
    chk("coin_strobe", int'(coin_strobe), int'(e.c));
    chk("coin_sel", int'(coin_sel), int'(e.sel));
    chk("busy", int'(busy), exp_busy);
    chk("active_id", int'(active_id), exp_busy ? m_active : 0);
    chk("done", int'(bus.done), e.d ? (1 << m_active) : 0);
    chk("err", int'(bus.err), int'(e.e));
    chk("shortfall", int'(bus.shortfall), int'(e.sh));
    if (!reset) begin
      if (bus.req_ready != 4'b0000) begin
        grant_log[grant_n % 64] = onehot_idx(bus.req_ready);
        grant_n++; grant_cyc = cyc; t_n = 0; c_n = 0; rec_seq = 20'd0;
      end
      if (ticket_strobe && !prev_t) begin
        if (t_n < 8) t_rise[t_n] = cyc - grant_cyc;
        t_n++;
      end
      if (coin_strobe && !prev_c) begin
        if (c_n < 16) c_rise[c_n] = cyc - grant_cyc;
        if (c_n < 10) rec_seq = rec_seq | (20'(coin_sel) << (2 * c_n));
        c_n++;
      end
      if (bus.done != 4'b0000) begin
        done_log[done_n % 64] = onehot_idx(bus.done);
        done_n++; done_off = cyc - grant_cyc;
        rec_err = int'(bus.err); rec_short = int'(bus.shortfall);
      end
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
      end else if (gi >= 0) begin
        tk = int'((bus.req_tickets >> (3 * gi)) & 12'h007);
        ch = int'((bus.req_change >> (7 * gi)) & 28'h000007F);
        m_active = gi; m_rr = (gi + 1) % 4;
        build(tk, ch, hopper);
      end
    end
    prev_t = reset ? 1'b0 : ticket_strobe;
    prev_c = reset ? 1'b0 : coin_strobe;
  end

  task automatic wait_grants(input int target);
    int k;
    k = 0;
    while (grant_n < target && k < 300) begin @(posedge clk); k++; end
    #1;
    chk("grant_wait", int'(grant_n >= target), 1);
  endtask

  task automatic wait_dones(input int target);
    int k;
    k = 0;
    while (done_n < target && k < 600) begin @(posedge clk); k++; end
    #1;
    chk("done_wait", int'(done_n >= target), 1);
  endtask

  task automatic set_job(input int fe, input int t, input int c);
    bus.req_tickets = (bus.req_tickets & ~(12'h007 << (3 * fe))) | (12'(t) << (3 * fe));
    bus.req_change  = (bus.req_change & ~(28'h000007F << (7 * fe))) | (28'(c) << (7 * fe));
  endtask

  task automatic run_job(input int fe, input int t, input int c);
    int g0, d0;
    set_job(fe, t, c);
    bus.req_valid = bus.req_valid | (4'b0001 << fe);
    g0 = grant_n; d0 = done_n;
    wait_grants(g0 + 1);
    bus.req_valid = bus.req_valid & ~(4'b0001 << fe);
    wait_dones(d0 + 1);
  endtask

  task automatic check_job(input int e_done, input int e_err, input int e_short,
                           input int e_tn, input int e_cn, input logic [19:0] e_seq);
    chk("job_done_latency", done_off, e_done);
    chk("job_err", rec_err, e_err);
    chk("job_shortfall", rec_short, e_short);
    chk("job_ticket_pulses", t_n, e_tn);
    chk("job_coin_pulses", c_n, e_cn);
    chk("job_coin_order", int'(rec_seq), int'(e_seq));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int g0, d0;
    reset = 1'b1; hopper = 4'b0000;
    bus.req_valid = 4'b0000; bus.req_tickets = 12'd0; bus.req_change = 28'd0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ticket", int'(ticket_strobe), 0);
    chk("rst_coin", int'(coin_strobe), 0);
    chk("rst_active", int'(active_id), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 2 tickets, change 6: coin 5 then coin 1, done at +25
    run_job(0, 2, 6);
    check_job(25, 0, 0, 2, 2, 20'({2'd0, 2'd1}));
    chk("t_rise0", t_rise[0], 1);
    chk("t_rise1", t_rise[1], 7);
    chk("c_rise0", c_rise[0], 13);
    chk("c_rise1", c_rise[1], 19);

    // change 67, all tubes full: 50,10,5,1,1
    run_job(0, 0, 67);
    check_job(1 + 5 * 6, 0, 0, 0, 5, 20'({2'd0, 2'd0, 2'd1, 2'd2, 2'd3}));

    // change 67 with 50-tube empty: 10 x6, 5, 1, 1
    hopper = 4'b1000;
    run_job(0, 0, 67);
    check_job(1 + 9 * 6, 0, 0, 0, 9,
              20'({2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}));

    // change 3 with 1-tube empty: nothing payable
    hopper = 4'b0001;
    run_job(0, 0, 3);
    check_job(1, 1, 3, 0, 0, 20'd0);
    hopper = 4'b0000;

    // rejected ticket count, then an empty job
    run_job(0, 6, 10);
    check_job(1, 1, 0, 0, 0, 20'd0);
    run_job(0, 0, 0);
    check_job(1, 0, 0, 0, 0, 20'd0);

    // all four requesting continuously after reset: 0,1,2,3,0
    pulse_reset();
    set_job(0, 0, 0); set_job(1, 1, 0); set_job(2, 0, 0); set_job(3, 0, 0);
    g0 = grant_n; d0 = done_n;
    bus.req_valid = 4'b1111;
    wait_grants(g0 + 5);
    bus.req_valid = 4'b0000;
    wait_dones(d0 + 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant_order", grant_log[(g0 + k) % 64], k % 4);
      chk("rr_done_owner", done_log[(d0 + k) % 64], k % 4);
    end

    // reset in the middle of a coin pulse
    pulse_reset();
    set_job(1, 0, 50);
    g0 = grant_n; d0 = done_n;
    bus.req_valid = 4'b0010;
    wait_grants(g0 + 1);
    bus.req_valid = 4'b0000;
    begin : find_coin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (coin_strobe) break;
      end
    end
    chk("coin_seen_before_reset", int'(coin_strobe), 1);
    chk("active_before_reset", int'(active_id), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_coin", int'(coin_strobe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_active", int'(active_id), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("no_done_after_reset", done_n, d0);
    set_job(0, 0, 0); set_job(3, 0, 0);
    g0 = grant_n; d0 = done_n;
    bus.req_valid = 4'b1001;
    wait_grants(g0 + 1);
    bus.req_valid = 4'b1000;
    chk("post_reset_first_grant", grant_log[g0 % 64], 0);
    wait_grants(g0 + 2);
    bus.req_valid = 4'b0000;
    chk("post_reset_second_grant", grant_log[(g0 + 1) % 64], 3);
    wait_dones(d0 + 2);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
